// File: rtl/axis_fifo.sv
// AXI-Stream synchronous FIFO, first-word-fall-through, one-cycle latency.
// Define AXIS_FIFO_LEVEL_EN to expose the occupancy count on output 'level'.
module axis_fifo #(
    parameter int DATA_W = 32,
    parameter int USER_W = 1,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    input  logic [USER_W-1:0] s_tuser,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic [USER_W-1:0] m_tuser,
    input  logic              m_tready
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [USER_W-1:0] user;
    } beat_t;

    beat_t         mem [DEPTH];
    beat_t         head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdy_en_q;
    logic          push, pop;

    // Ready comes only from registered state, never from m_tready, so a
    // pop on a full FIFO cannot admit a push on the same edge.
    assign s_tready = rdy_en_q && (count_q != CW'(DEPTH));
    assign m_tvalid = (count_q != '0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    assign head     = mem[rd_ptr_q];
    assign m_tdata  = head.data;
    assign m_tlast  = head.last;
    assign m_tuser  = head.user;

`ifdef AXIS_FIFO_LEVEL_EN
    assign level = count_q;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Payload storage carries no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= '{data: s_tdata, last: s_tlast, user: s_tuser};
    end

endmodule
